// File: rtl/hurricane_timer_if.sv
// hurricane_timer_if: mode-controller side bundle of the hurricane timer.
// master drives mode/power/buttons; slave is the timer itself.
interface hurricane_timer_if;
   logic        machine_state;
   logic [2:0]  mode_state;
   logic        menu_btn;
   logic        cum_clr;
   logic        hurricane_mode_enabled;
   logic        return_state;
   logic        countdown_active;
   logic [6:0]  countdown_sec;
   logic [19:0] cum_sec;

   modport master (
      output machine_state, mode_state, menu_btn, cum_clr,
      input  hurricane_mode_enabled, return_state,
      input  countdown_active, countdown_sec, cum_sec
   );

   modport slave (
      input  machine_state, mode_state, menu_btn, cum_clr,
      output hurricane_mode_enabled, return_state,
      output countdown_active, countdown_sec, cum_sec
   );
endinterface

// File: rtl/hurricane_timer.sv
// hurricane_timer: level-3 countdown plus cumulative fan-run seconds.
// HURRICANE_LOCKOUT_EN: after an expiry, level 3 stays locked until power-off.
module hurricane_timer #(
   parameter int unsigned TICKS_PER_SEC = 100_000_000,
   parameter int unsigned HURRICANE_SEC = 60,
   parameter logic [19:0] CUM_INIT      = '0
) (
   input  logic             clk,
   input  logic             rst,
   hurricane_timer_if.slave bus
);

   localparam int unsigned TW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_SEC - 1);
   localparam logic [6:0]    HSEC      = 7'(HURRICANE_SEC);
   localparam logic [2:0]    MODE_HUR  = 3'b011;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e        state_q, state_d;
   logic [TW-1:0] htick_q, htick_d;
   logic [TW-1:0] ctick_q, ctick_d;
   logic [6:0]    cnt_q, cnt_d;
   logic          act_q, act_d;
   logic          en_q, en_d;
   logic          ret_q, ret_d;
   logic          lock_q, lock_d;
   logic [2:0]    mode_prev_q;
   logic          menu_prev_q;
   logic [19:0]   cum_q, cum_d;

   logic hur, entry, menu_edge, sec_pulse;
   logic cum_run, cum_pulse, lock_set;

`ifdef HURRICANE_LOCKOUT_EN
   assign lock_set = 1'b1;
`else
   assign lock_set = 1'b0;
`endif

   assign hur       = bus.mode_state == MODE_HUR;
   assign entry     = hur && (mode_prev_q != MODE_HUR)
                      && bus.machine_state && !lock_q;
   assign menu_edge = bus.menu_btn && !menu_prev_q;
   assign sec_pulse = htick_q == TICK_LAST;

   always_comb begin
      state_d = state_q;
      htick_d = htick_q;
      cnt_d   = cnt_q;
      act_d   = act_q;
      en_d    = en_q;
      ret_d   = ret_q;
      lock_d  = lock_q;
      if (!bus.machine_state) begin
         state_d = IDLE;
         htick_d = '0;
         cnt_d   = '0;
         act_d   = 1'b0;
         en_d    = 1'b1;
         ret_d   = 1'b1;
         lock_d  = 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               en_d = !lock_q;
               if (entry) begin
                  state_d = RUN;
                  cnt_d   = HSEC;
                  htick_d = '0;
                  ret_d   = 1'b1;
                  act_d   = 1'b1;
               end
            end
            RUN: begin
               if (!hur) begin
                  state_d = IDLE;
                  htick_d = '0;
                  cnt_d   = '0;
                  act_d   = 1'b0;
                  ret_d   = 1'b1;
                  en_d    = 1'b1;
               end else if (menu_edge) begin
                  // menu edge outranks a coincident final second
                  cnt_d   = HSEC;
                  htick_d = '0;
                  ret_d   = 1'b0;
               end else if (sec_pulse) begin
                  htick_d = '0;
                  cnt_d   = cnt_q - 7'd1;
                  if (cnt_q == 7'd1) begin
                     state_d = DONE;
                     act_d   = 1'b0;
                     en_d    = 1'b0;
                  end
               end else begin
                  htick_d = htick_q + TW'(1);
               end
            end
            DONE: begin
               en_d = 1'b0;
               if (!hur) begin
                  state_d = IDLE;
                  lock_d  = lock_set;
                  en_d    = !lock_set;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   assign cum_run   = bus.machine_state
                      && (bus.mode_state inside {3'b001, 3'b010, 3'b011});
   assign cum_pulse = cum_run && (ctick_q == TICK_LAST);

   always_comb begin
      ctick_d = ctick_q;
      cum_d   = cum_q;
      if (bus.cum_clr) begin
         ctick_d = '0;
         cum_d   = '0;
      end else if (cum_run) begin
         ctick_d = cum_pulse ? '0 : ctick_q + TW'(1);
         if (cum_pulse && (cum_q != '1)) cum_d = cum_q + 20'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         htick_q     <= '0;
         ctick_q     <= '0;
         cnt_q       <= '0;
         act_q       <= 1'b0;
         en_q        <= 1'b1;
         ret_q       <= 1'b1;
         lock_q      <= 1'b0;
         mode_prev_q <= '0;
         menu_prev_q <= 1'b0;
         cum_q       <= CUM_INIT;
      end else begin
         state_q     <= state_d;
         htick_q     <= htick_d;
         ctick_q     <= ctick_d;
         cnt_q       <= cnt_d;
         act_q       <= act_d;
         en_q        <= en_d;
         ret_q       <= ret_d;
         lock_q      <= lock_d;
         mode_prev_q <= bus.mode_state;
         menu_prev_q <= bus.menu_btn;
         cum_q       <= cum_d;
      end
   end

   assign bus.hurricane_mode_enabled = en_q;
   assign bus.return_state           = ret_q;
   assign bus.countdown_active       = act_q;
   assign bus.countdown_sec          = cnt_q;
   assign bus.cum_sec                = cum_q;

endmodule

// File: tb/tb_hurricane_timer.sv
// tb_hurricane_timer: scoreboard bench for hurricane_timer.
// TICKS_PER_SEC=4, HURRICANE_SEC=3; second instance preloads cum_sec.
module tb_hurricane_timer;

   logic clk;
   logic rst;

   hurricane_timer_if bus ();
   hurricane_timer_if bus2 ();

   hurricane_timer #(
      .TICKS_PER_SEC(4),
      .HURRICANE_SEC(3)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   hurricane_timer #(
      .TICKS_PER_SEC(4),
      .HURRICANE_SEC(3),
      .CUM_INIT(20'hFFFFD)
   ) dut_sat (
      .clk(clk),
      .rst(rst),
      .bus(bus2)
   );

`ifdef HURRICANE_LOCKOUT_EN
   localparam logic LOCK = 1'b1;
`else
   localparam logic LOCK = 1'b0;
`endif

   typedef struct {
      string       tag;
      int          sel;
      logic [19:0] val;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fails = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [19:0] got,
                      input logic [19:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [19:0] obs(input int sel);
      case (sel)
         0:       return {19'd0, bus.hurricane_mode_enabled};
         1:       return {19'd0, bus.return_state};
         2:       return {19'd0, bus.countdown_active};
         3:       return {13'd0, bus.countdown_sec};
         4:       return bus.cum_sec;
         default: return bus2.cum_sec;
      endcase
   endfunction

   task automatic push(input string tag, input int sel,
                       input logic [19:0] val);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.val = val;
      sb.push_back(e);
   endtask

   task automatic push_st(input string tag, input logic en,
                          input logic ret, input logic act,
                          input logic [6:0] cnt);
      push({tag, ".en"}, 0, {19'd0, en});
      push({tag, ".ret"}, 1, {19'd0, ret});
      push({tag, ".act"}, 2, {19'd0, act});
      push({tag, ".cnt"}, 3, {13'd0, cnt});
   endtask

   task automatic drain();
      exp_t e;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         chk(e.tag, obs(e.sel), e.val);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         drain();
      end
   endtask

   // steps 1..12 after a load/reload edge
   task automatic countdown(input string tag, input logic ret);
      logic [6:0] c;
      for (int i = 1; i <= 12; i++) begin
         c = (i < 4) ? 7'd3 : (i < 8) ? 7'd2 : (i < 12) ? 7'd1 : 7'd0;
         push_st(tag, i < 12, ret, i < 12, c);
         cyc(1);
      end
   endtask

   task automatic power_pulse();
      bus.machine_state = 1'b0;
      push("pwr.en", 0, 20'd1);
      cyc(1);
      bus.machine_state = 1'b1;
      cyc(1);
   endtask

   initial begin
      rst = 1'b0;
      bus.machine_state  = 1'b1;
      bus.mode_state     = 3'b000;
      bus.menu_btn       = 1'b0;
      bus.cum_clr        = 1'b0;
      bus2.machine_state = 1'b1;
      bus2.mode_state    = 3'b000;
      bus2.menu_btn      = 1'b0;
      bus2.cum_clr       = 1'b0;

      #12;
      push_st("rst", 1'b1, 1'b1, 1'b0, 7'd0);
      push("rst.cum", 4, 20'd0);
      drain();
      #8 rst = 1'b1;
      cyc(2);

      // plain expiry
      bus.mode_state = 3'b011;
      push_st("load", 1'b1, 1'b1, 1'b1, 7'd3);
      cyc(1);
      countdown("run", 1'b1);
      push_st("done", 1'b0, 1'b1, 1'b0, 7'd0);
      cyc(1);
      bus.mode_state = 3'b010;
      push("exit.en", 0, {19'd0, !LOCK});
      cyc(1);
      for (int i = 0; i < 3; i++) begin
         push("hold.en", 0, {19'd0, !LOCK});
         cyc(1);
      end
      power_pulse();
      bus.mode_state = 3'b000;
      cyc(1);

      // menu press at cycle 6
      bus.mode_state = 3'b011;
      push_st("m.load", 1'b1, 1'b1, 1'b1, 7'd3);
      cyc(1);
      cyc(4);
      push("m.pre", 3, 20'd2);
      cyc(1);
      bus.menu_btn = 1'b1;
      push_st("m.press", 1'b1, 1'b0, 1'b1, 7'd3);
      cyc(1);
      countdown("m.run", 1'b0);
      bus.menu_btn = 1'b0;
      bus.mode_state = 3'b000;
      cyc(1);
      power_pulse();

      // menu edge coincident with final second
      bus.mode_state = 3'b011;
      push_st("s.load", 1'b1, 1'b1, 1'b1, 7'd3);
      cyc(1);
      cyc(10);
      push("s.pre", 3, 20'd1);
      cyc(1);
      bus.menu_btn = 1'b1;
      push_st("s.race", 1'b1, 1'b0, 1'b1, 7'd3);
      cyc(1);
      bus.menu_btn = 1'b0;
      countdown("s.run", 1'b0);
      bus.mode_state = 3'b000;
      cyc(1);
      power_pulse();

      // leave 011 mid-run
      bus.mode_state = 3'b011;
      push_st("a.load", 1'b1, 1'b1, 1'b1, 7'd3);
      cyc(1);
      cyc(5);
      bus.mode_state = 3'b010;
      push_st("a.abort", 1'b1, 1'b1, 1'b0, 7'd0);
      cyc(1);
      push("a.idle.en", 0, 20'd1);
      cyc(1);

      // power drop mid-run, cum retained
      bus.mode_state = 3'b000;
      bus.cum_clr = 1'b1;
      push("d.clr", 4, 20'd0);
      cyc(1);
      bus.cum_clr = 1'b0;
      bus.mode_state = 3'b011;
      push_st("d.load", 1'b1, 1'b1, 1'b1, 7'd3);
      cyc(1);
      cyc(1);
      push("d.cum0", 4, 20'd0);
      cyc(1);
      push("d.cum1", 4, 20'd1);
      cyc(1);
      cyc(2);
      bus.machine_state = 1'b0;
      push_st("d.drop", 1'b1, 1'b1, 1'b0, 7'd0);
      push("d.cum", 4, 20'd1);
      cyc(1);
      for (int i = 0; i < 8; i++) begin
         push("d.hold", 4, 20'd1);
         cyc(1);
      end
      bus.machine_state = 1'b1;
      bus.mode_state = 3'b000;
      cyc(1);

      // cumulative counting and clear
      bus.cum_clr = 1'b1;
      push("c.clr0", 4, 20'd0);
      cyc(1);
      bus.cum_clr = 1'b0;
      bus.mode_state = 3'b010;
      cyc(19);
      push("c.20", 4, 20'd5);
      cyc(1);
      cyc(19);
      push("c.40", 4, 20'd10);
      cyc(1);
      bus.cum_clr = 1'b1;
      push("c.clr1", 4, 20'd0);
      cyc(1);
      bus.cum_clr = 1'b0;
      bus.mode_state = 3'b000;
      cyc(1);

      // async reset mid-run
      bus.mode_state = 3'b011;
      push_st("r.load", 1'b1, 1'b1, 1'b1, 7'd3);
      cyc(1);
      cyc(5);
      #2 rst = 1'b0;
      #1;
      push_st("r.async", 1'b1, 1'b1, 1'b0, 7'd0);
      push("r.cum", 4, 20'd0);
      drain();
      @(negedge clk);
      bus.mode_state = 3'b000;
      @(negedge clk);
      rst = 1'b1;
      cyc(1);

      // saturation on preloaded instance
      bus2.mode_state = 3'b001;
      cyc(3);
      push("sat.1", 5, 20'hFFFFE);
      cyc(1);
      cyc(3);
      push("sat.2", 5, 20'hFFFFF);
      cyc(1);
      cyc(3);
      push("sat.3", 5, 20'hFFFFF);
      cyc(1);
      cyc(3);
      push("sat.4", 5, 20'hFFFFF);
      cyc(1);

      if (sb.size() != 0) begin
         n_fails++;
         $display("FAIL scoreboard leftover=%0d", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fails);
      $finish;
   end

endmodule
